// File: rtl/bus_seq_pkg.sv
// Shared types and defaults for the bus sequence checker.
// State encoding is visible on the state output, so values are fixed.
package bus_seq_pkg;

    localparam int             DEF_DATA_W    = 16;
    localparam int             DEF_FLAG_W    = 4;
    localparam logic [3:0]     DEF_FLAG_VAL  = 4'hF;
    localparam int             DEF_SEQ_W     = 4;
    localparam int             DEF_ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIRST    = 3'd1,
        ST_REG      = 3'd2,
        ST_FLAG_ERR = 3'd3,
        ST_SEQ_ERR  = 3'd4
    } state_e;

    function automatic logic is_err_state(input state_e s);
        return (s == ST_FLAG_ERR) || (s == ST_SEQ_ERR);
    endfunction

    function automatic logic is_stream_state(input state_e s);
        return (s == ST_FIRST) || (s == ST_REG);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
// Used for the bad-word tally of the sequence checker.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on request unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bus_seq_checker.sv
// Packet-framing checker: verifies header flag and rolling sequence
// number, forwards good words with one cycle of latency.
module bus_seq_checker
    import bus_seq_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                FLAG_W    = DEF_FLAG_W,
    parameter logic [FLAG_W-1:0] FLAG_VAL  = DEF_FLAG_VAL,
    parameter int                SEQ_W     = DEF_SEQ_W,
    parameter int                ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 valid_out,
    output logic [DATA_W-1:0]    data_out,
    output logic [2:0]           state,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [SEQ_W-1:0]     seq_expected
);

    // The flag and sequence fields must not overlap inside the word.
    if (FLAG_W + SEQ_W > DATA_W) begin : g_bad_fields
        $fatal(1, "bus_seq_checker: FLAG_W+SEQ_W exceeds DATA_W");
    end

    logic              flag_ok;
    logic [SEQ_W-1:0]  seq;

    assign flag_ok = (data_in[DATA_W-1 -: FLAG_W] == FLAG_VAL);
    assign seq     = data_in[SEQ_W-1:0];

    state_e            state_q,     state_d;
    logic              valid_out_q, valid_out_d;
    logic [DATA_W-1:0] data_out_q,  data_out_d;
    logic              error_q,     error_d;
    logic [SEQ_W-1:0]  seq_exp_q,   seq_exp_d;
    logic              bad_word;

    // Next-state, sequence tracking and output-register inputs.
    always_comb begin
        state_d     = state_q;
        seq_exp_d   = seq_exp_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        bad_word    = 1'b0;

        if (valid_in) begin
            case (state_q)
                ST_IDLE, ST_FLAG_ERR, ST_SEQ_ERR: begin
                    // Resynchronise: the word itself sets the base.
                    if (flag_ok) begin
                        state_d   = ST_FIRST;
                        seq_exp_d = seq + 1'b1;
                    end else begin
                        state_d   = ST_FLAG_ERR;
                    end
                end
                ST_FIRST, ST_REG: begin
                    // Flag check takes priority over sequence check.
                    if (!flag_ok) begin
                        state_d   = ST_FLAG_ERR;
                    end else if (seq != seq_exp_q) begin
                        state_d   = ST_SEQ_ERR;
                    end else begin
                        state_d   = ST_REG;
                        seq_exp_d = seq_exp_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (is_stream_state(state_d)) begin
                valid_out_d = 1'b1;
                data_out_d  = data_in;
            end else begin
                bad_word    = 1'b1;
            end
        end

        error_d = is_err_state(state_d);
    end

    // Pipeline registers; everything visible on the ports lives here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            error_q     <= 1'b0;
            seq_exp_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            error_q     <= error_d;
            seq_exp_q   <= seq_exp_d;
        end
    end

    sat_counter #(
        .W     (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bad_word),
        .count (err_count)
    );

    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign state        = state_q;
    assign error        = error_q;
    assign seq_expected = seq_exp_q;

endmodule

// File: tb/tb_bus_seq_checker.sv
// Scoreboard bench for bus_seq_checker: directed plan plus random
// traffic against a word-level reference model.
module tb_bus_seq_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic [15:0] data_out;
    logic [2:0]  state;
    logic        error;
    logic [7:0]  err_count;
    logic [3:0]  seq_expected;

    bus_seq_checker dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .state        (state),
        .error        (error),
        .err_count    (err_count),
        .seq_expected (seq_expected)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic        vo;
        logic [15:0] d;
        logic        er;
        logic [7:0]  cnt;
        logic [3:0]  sq;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_vec = 0;
    int    n_err = 0;
    string phase = "reset";

    // Reference model: state as an integer label, counters as plain ints.
    int          m_st;
    int          m_exp;
    int          m_cnt;
    logic [15:0] m_dout;
    logic        m_vo;

    function automatic exp_t model_out();
        exp_t e;
        e.st  = 3'(m_st);
        e.vo  = m_vo;
        e.d   = m_dout;
        e.er  = (m_st == 3) || (m_st == 4);
        e.cnt = 8'(m_cnt);
        e.sq  = 4'(m_exp);
        return e;
    endfunction

    task automatic model_reset();
        m_st = 0; m_exp = 0; m_cnt = 0; m_dout = '0; m_vo = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d);
        int s;
        bit fok;
        bit in_stream;
        s         = int'(d[3:0]);
        fok       = (d[15:12] == 4'hF);
        in_stream = (m_st == 1) || (m_st == 2);
        if (!v) begin
            m_vo = 1'b0;
            return;
        end
        if (fok && (!in_stream || s == m_exp)) begin
            m_st   = in_stream ? 2 : 1;
            m_exp  = (s + 1) % 16;
            m_vo   = 1'b1;
            m_dout = d;
        end else begin
            m_st = fok ? 4 : 3;
            m_vo = 1'b0;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (state !== e.st || valid_out !== e.vo || data_out !== e.d ||
            error !== e.er || err_count !== e.cnt || seq_expected !== e.sq) begin
            n_err++;
            $display("FAIL %s [%s]: got st=%0d vo=%0b d=%h er=%0b cnt=%0d sq=%0d, want st=%0d vo=%0b d=%h er=%0b cnt=%0d sq=%0d",
                     name, phase, state, valid_out, data_out, error, err_count,
                     seq_expected, e.st, e.vo, e.d, e.er, e.cnt, e.sq);
        end
    endtask

    // Monitor: one expected record per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cycle", mon_e);
        end
    end

    task automatic drive(input logic v, input logic [15:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        model_step(v, d);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        #2;
        model_reset();
        check("async_reset", model_out());
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [15:0] plan1 [12] = '{16'hFBA0, 16'hF0A1, 16'hF102, 16'hA5D3,
                                16'hF1F0, 16'hFDC1, 16'hF000, 16'hF001,
                                16'hF003, 16'hF004, 16'hF00E, 16'hF00F};

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        model_reset();
        #1;
        check("reset_value", model_out());
        #12;
        @(posedge clk);
        #1;
        reset = 1'b0;

        phase = "plan1-4";
        foreach (plan1[i]) drive(1'b1, plan1[i]);
        drive(1'b1, 16'hF000);

        phase = "gaps";
        drive(1'b1, 16'hF000);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h1234);
        drive(1'b1, 16'hF001);

        phase = "saturate";
        for (int i = 0; i < 260; i++) drive(1'b1, 16'h0000);
        drive(1'b1, 16'hF003);
        do_reset();

        phase = "random";
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] w;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      w = {4'hF, 8'($urandom), 4'(m_exp)};
            else if (r < 8) w = {4'hF, 12'($urandom)};
            else            w = 16'($urandom);
            drive($urandom_range(0, 3) != 0, w);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        valid_in = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #6;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
